// File: rtl/unsigned_32_bit_adder.sv
// Registered 32-bit unsigned ripple-carry adder.
// Exposes the sum and every stage carry-out, one cycle after the operands.
module unsigned_32_bit_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin,
    output logic [31:0] sout,
    output logic [31:0] cout
);

    logic [31:0] prop;
    logic [31:0] gen;
    logic [32:0] carry;
    logic [31:0] sum;

    // Per-bit propagate and generate terms for the full-adder cells.
    always_comb begin
        prop = in1 ^ in2;
        gen  = in1 & in2;
    end

    // Ripple the carry from bit 0 up through all 32 full-adder stages.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]     = prop[i] ^ carry[i];
            carry[i+1] = gen[i] | (carry[i] & prop[i]);
        end
    end

    // Output registers; reset wins over the load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sout <= '0;
            cout <= '0;
        end else begin
            sout <= sum;
            cout <= carry[32:1];
        end
    end

endmodule

// File: tb/tb_unsigned_32_bit_adder.sv
// Bench for unsigned_32_bit_adder.
// Vector table, reset/hold sequences and a random run against a model.
module tb_unsigned_32_bit_adder;

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        cin;
    logic [31:0] sout;
    logic [31:0] cout;

    int total;
    int bad;

    unsigned_32_bit_adder dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (in1),
        .in2  (in2),
        .cin  (cin),
        .sout (sout),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] exp_s;
        logic [31:0] exp_c;
        logic [31:0] c_mask;
    } vec_t;

    vec_t vecs[10];

    // Reference: cout[i] is bit i+1 of the sum of the low i+1 bits.
    function automatic logic [31:0] ref_cout(
        input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [63:0] m;
        logic [63:0] t;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            m = (64'd1 << (i + 1)) - 64'd1;
            t = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c};
            r[i] = t[i+1];
        end
        return r;
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic c);
        in1 = a;
        in2 = b;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [32:0] full;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        rr;

        total = 0;
        bad   = 0;

        vecs[0] = '{32'd1000, 32'd1010, 1'b0,
                    32'd2010, 32'h0, 32'h8000_0000};
        vecs[1] = '{32'd1000000, 32'd1000010, 1'b0,
                    32'd2000010, 32'h0, 32'h8000_0000};
        vecs[2] = '{32'd25, 32'd6, 1'b0,
                    32'd31, 32'h0, 32'hFFFF_FFFF};
        vecs[3] = '{32'd55, 32'd5, 1'b0,
                    32'd60, 32'h7, 32'hFFFF_FFFF};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                    32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0, 1'b1,
                    32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{32'h0, 32'h0, 1'b1,
                    32'h1, 32'h0, 32'hFFFF_FFFF};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0,
                    32'h0, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[9] = '{32'h0000_000F, 32'h0000_0001, 1'b0,
                    32'h10, 32'h0000_000F, 32'hFFFF_FFFF};

        rst = 1'b1;
        in1 = 32'h1234_5678;
        in2 = 32'h9ABC_DEF0;
        cin = 1'b1;
        @(posedge clk);
        #1;
        check("reset_sout", sout, 32'h0);
        check("reset_cout", cout, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load(vecs[i].a, vecs[i].b, vecs[i].c);
            check($sformatf("vec%0d_sout", i), sout, vecs[i].exp_s);
            check($sformatf("vec%0d_cout", i),
                  cout & vecs[i].c_mask, vecs[i].exp_c);
        end

        load(32'd55, 32'd5, 1'b0);
        in1 = 32'hDEAD_BEEF;
        in2 = 32'h0BAD_F00D;
        cin = 1'b1;
        #3;
        check("hold_sout", sout, 32'd60);
        check("hold_cout", cout, 32'h7);

        load(32'd55, 32'd5, 1'b0);
        rst = 1'b1;
        #3;
        check("rst_midcycle_sout", sout, 32'd60);
        check("rst_midcycle_cout", cout, 32'h7);
        @(posedge clk);
        #1;
        check("rst_edge_sout", sout, 32'h0);
        check("rst_edge_cout", cout, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_sout", sout, 32'd60);
        check("rst_release_cout", cout, 32'h7);

        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: rb = ~ra;
                default: ;
            endcase
            rr = ($urandom_range(0, 63) == 0);
            rst = rr;
            load(ra, rb, rc);
            if (rr) begin
                check("rand_rst_sout", sout, 32'h0);
                check("rand_rst_cout", cout, 32'h0);
            end else begin
                full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
                check("rand_sum33", {cout[31], sout}, full);
                check("rand_cout", cout, ref_cout(ra, rb, rc));
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unsigned_32_bit_adder.md
UNSIGNED_32_BIT_ADDER -- requirements
Module: unsigned_32_bit_adder

Interface
- REQ-001: The block SHALL have no parameters; operand width is fixed at 32 bits.
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, synchronous and active-high.
- REQ-004: in1  input  32  unsigned operand A.
- REQ-005: in2  input  32  unsigned operand B.
- REQ-006: cin  input  1  carry-in to bit 0.
- REQ-007: sout  output  32  registered sum bits, in1+in2+cin modulo 2^32.
- REQ-008: cout  output  32  registered per-bit carry-out vector; cout[i] is the carry out of bit position i, and cout[31] is the overall carry out.

Function
- REQ-009: Datapath SHALL be a 32-stage ripple-carry chain of 1-bit full adders: s[i]=a[i]^b[i]^c[i]; c[i+1]=(a[i]&b[i])|(c[i]&(a[i]^b[i])); c[0]=cin.
- REQ-010: cout[i] SHALL equal c[i+1] from the REQ-009 chain.
- REQ-011: On each rising clk edge with rst=0, sout and cout SHALL load the values for the in1/in2/cin present before that edge.
- REQ-012: Latency SHALL be exactly 1 cycle; a new operand set SHALL be accepted every cycle, with no handshake and no stall.
- REQ-013: Between clock edges, sout and cout SHALL hold their last registered values regardless of input changes.
- REQ-014: Arithmetic SHALL be unsigned.
  - The 33-bit result {cout[31], sout} SHALL equal in1+in2+cin exactly.
  - On overflow, sout wraps modulo 2^32 and cout[31]=1.
- REQ-015: Max-value case: in1=in2=32'hFFFFFFFF with cin=1 SHALL give sout=32'hFFFFFFFF and cout=32'hFFFFFFFF.
- REQ-016: A carry generated at bit 0 SHALL propagate through all 32 stages within a single cycle.
- REQ-017: X or Z on any input is outside scope; outputs are then undefined until the next valid load.

Reset
- REQ-018: When rst=1 at a rising clk edge, sout and cout SHALL both become 32'h0, taking priority over any load.
- REQ-019: Reset SHALL be synchronous only; asserting rst between edges SHALL NOT change the outputs until the next rising edge.
- REQ-020: Reset during continuous operation SHALL discard the operands sampled at that edge. The first edge with rst=0 SHALL load the current operands normally.
- REQ-021: The block SHALL hold no state other than the sout and cout registers.

Verification
- REQ-022: in1=1000, in2=1010, cin=0 -> one edge later, sout=2010 and cout[31]=0.
- REQ-023: in1=1000000, in2=1000010, cin=0 -> sout=2000010, cout[31]=0.
- REQ-024: in1=25, in2=6, cin=0 -> sout=31, cout=32'h0. Then in1=55, in2=5, cin=0 -> sout=60, cout=32'h7.
- REQ-025: in1=in2=32'hFFFFFFFF, cin=0 -> sout=32'hFFFFFFFE, cout=32'hFFFFFFFF. Repeat with cin=1 -> sout=32'hFFFFFFFF.
- REQ-026: in1=32'hFFFFFFFF, in2=0, cin=1 -> sout=32'h0, cout=32'hFFFFFFFF (full ripple propagation).
- REQ-027: Load a nonzero result, then assert rst for one edge with inputs unchanged -> sout=0 and cout=0 after that edge. Deassert rst -> the result reappears one edge later.
- REQ-028: Random regression of at least 10k vectors SHALL check {cout[31], sout} against in1+in2+cin computed at 33 bits, delayed by one cycle.
